data_line_buffer: RTL

Parametrised successor to the single-line data store. It holds one cache line of LINE_BYTES bytes and supports byte-masked CPU writes with per-byte dirty tracking. It also supports multi-beat line refill and multi-beat write-back eviction over valid/ready handshakes. It sits between the cache controller / tag compare logic and the memory-side refill/write-back path, one instance per line.

---
 rtl/cache_pkg.sv | 17 +
 rtl/line_byte_bank.sv | 47 ++++
 rtl/data_line_buffer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Types and constants shared by the line buffer and its byte banks.
package cache_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    EVICT = 2'd2
  } state_t;

  // Beat counter needs at least one bit even when a line is a single beat.
  function automatic int cnt_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/line_byte_bank.sv
// One byte of line storage with async active-low reset and write enable.
// With DATA_LINE_PARITY_EN defined it also keeps an even-parity bit per byte.
module line_byte_bank
  import cache_pkg::*;
#(
  parameter logic [BYTE_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [BYTE_W-1:0] d,
  output logic [BYTE_W-1:0] q
`ifdef DATA_LINE_PARITY_EN
  ,
  input  logic              par_flip,
  output logic              par_err
`endif
);

  logic [BYTE_W-1:0] byte_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_reg <= INIT_VAL;
    end else if (we) begin
      byte_reg <= d;
    end
  end

  assign q = byte_reg;

`ifdef DATA_LINE_PARITY_EN
  logic par_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      par_reg <= ^INIT_VAL;
    end else if (we) begin
      par_reg <= ^d;
    end
  end

  // par_flip inverts the stored parity as seen by the checker.
  assign par_err = (^byte_reg) ^ par_reg ^ par_flip;
`endif

endmodule

// File: rtl/data_line_buffer.sv
// Single cache line store: masked CPU writes, dirty tracking, multi-beat refill/evict.
// Optional byte parity checking on eviction is enabled by defining DATA_LINE_PARITY_EN.
module data_line_buffer
  import cache_pkg::*;
#(
  parameter int          LINE_BYTES = 16,
  parameter int          BEAT_BYTES = 4,
  parameter logic [7:0]  INIT_VAL   = 8'h00
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_en,
  input  logic [LINE_BYTES-1:0]        wr_mask,
  input  logic [LINE_BYTES*8-1:0]      wr_data,
  output logic [LINE_BYTES*8-1:0]      rd_data,
  input  logic                         fill_start,
  input  logic                         fill_valid,
  output logic                         fill_ready,
  input  logic [BEAT_BYTES*8-1:0]      fill_data,
  output logic                         fill_done,
  input  logic                         evict_start,
  output logic                         evict_valid,
  input  logic                         evict_ready,
  output logic [BEAT_BYTES*8-1:0]      evict_data,
  output logic                         evict_last,
  output logic                         busy,
  output logic                         dirty,
  output logic [LINE_BYTES-1:0]        dirty_mask,
  output logic                         parity_err
);

  localparam int NUM_BEATS = LINE_BYTES / BEAT_BYTES;
  localparam int CNT_W     = cnt_width(NUM_BEATS);
  localparam int BEAT_W    = BEAT_BYTES * BYTE_W;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BEATS - 1);

  state_t                  state_reg, state_next;
  logic [CNT_W-1:0]        cnt_reg, cnt_next;
  logic                    fill_done_reg;
  logic [LINE_BYTES-1:0]   dirty_mask_reg;

  logic                    fill_hs;
  logic                    evict_hs;
  logic                    beat_last;
  logic                    cpu_wr;
  logic                    op_done;
  logic [LINE_BYTES-1:0]   byte_we;
  logic [NUM_BEATS-1:0][BEAT_W-1:0] beats;

  assign fill_hs   = (state_reg == FILL) && fill_valid;
  assign evict_hs  = (state_reg == EVICT) && evict_ready;
  assign beat_last = (cnt_reg == LAST_CNT);
  assign cpu_wr    = (state_reg == IDLE) && wr_en;
  assign op_done   = (fill_hs || evict_hs) && beat_last;

`ifdef DATA_LINE_PARITY_EN
  logic [LINE_BYTES-1:0] byte_perr;
  logic                  parity_flip_byte0;

  // Held low in hardware; a bench may force it to corrupt byte 0 parity.
  assign parity_flip_byte0 = 1'b0;
`endif

  // Refill beats land on the byte lanes selected by the beat counter;
  // CPU writes can only happen in IDLE, so the two sources never collide.
  generate
    for (genvar gi = 0; gi < LINE_BYTES; gi++) begin : gen_byte
      localparam int BEAT_IDX = gi / BEAT_BYTES;
      localparam int LANE     = gi % BEAT_BYTES;
      logic [BYTE_W-1:0] byte_d;

      assign byte_we[gi] = (cpu_wr && wr_mask[gi]) ||
                           (fill_hs && (cnt_reg == CNT_W'(BEAT_IDX)));
      assign byte_d = (state_reg == FILL) ? fill_data[LANE*BYTE_W +: BYTE_W]
                                          : wr_data[gi*BYTE_W +: BYTE_W];

      line_byte_bank #(
        .INIT_VAL (INIT_VAL)
      ) u_bank (
        .clk      (clk),
        .reset    (reset),
        .we       (byte_we[gi]),
        .d        (byte_d),
        .q        (rd_data[gi*BYTE_W +: BYTE_W])
`ifdef DATA_LINE_PARITY_EN
        ,
        .par_flip ((gi == 0) ? parity_flip_byte0 : 1'b0),
        .par_err  (byte_perr[gi])
`endif
      );
    end
  endgenerate

  assign beats      = rd_data;
  assign evict_data = beats[cnt_reg];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      fill_done_reg  <= 1'b0;
      dirty_mask_reg <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      fill_done_reg <= fill_hs && beat_last;
      if (op_done) begin
        dirty_mask_reg <= '0;
      end else if (cpu_wr) begin
        dirty_mask_reg <= dirty_mask_reg | wr_mask;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (evict_start) begin
          state_next = EVICT;
        end else if (fill_start) begin
          state_next = FILL;
        end
      end
      FILL, EVICT: begin
        if (fill_hs || evict_hs) begin
          if (beat_last) begin
            state_next = IDLE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    fill_ready  = (state_reg == FILL);
    evict_valid = (state_reg == EVICT);
    evict_last  = (state_reg == EVICT) && beat_last;
    busy        = (state_reg != IDLE);
  end

  assign fill_done  = fill_done_reg;
  assign dirty_mask = dirty_mask_reg;
  assign dirty      = |dirty_mask_reg;

`ifdef DATA_LINE_PARITY_EN
  logic [NUM_BEATS-1:0][BEAT_BYTES-1:0] beat_perr;
  logic                                 parity_err_reg;

  assign beat_perr = byte_perr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      parity_err_reg <= 1'b0;
    end else if (evict_hs && (|beat_perr[cnt_reg])) begin
      parity_err_reg <= 1'b1;
    end
  end

  assign parity_err = parity_err_reg;
`else
  assign parity_err = 1'b0;
`endif

endmodule
